// File: rtl/clock_divider_bank_if.sv
// Control/status bundle for clock_divider_bank: per-channel enable, mode and
// ratio inputs, the shared load/sync strobes, and the divided outputs.
interface clock_divider_bank_if #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 24
);
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic                    load;
  logic                    sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       pending;

  // Controller side: drives configuration, observes the strobes.
  modport master (
    output enable, mode, div_ratio, load, sync,
    input  clk_out, pending
  );

  // Divider side.
  modport slave (
    input  enable, mode, div_ratio, load, sync,
    output clk_out, pending
  );
endinterface

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: NUM_CH independent programmable dividers of the system
// clock. Each channel produces a registered square wave or one-cycle tick.
// A new ratio can be staged at any time and is applied only at the channel's
// period boundary, so there is never a runt or stretched period. A global sync
// restarts every enabled channel phase-aligned.
module clock_divider_bank #(
  parameter int                      NUM_CH      = 3,
  parameter int                      DIV_W       = 24,
  parameter logic [NUM_CH*DIV_W-1:0] DEFAULT_DIV = {24'd2941176, 24'd5882, 24'd2500}
) (
  input  logic                 clk,
  input  logic                 reset,
  clock_divider_bank_if.slave  bus
);

  typedef logic [DIV_W-1:0] ratio_t;

  // Ratios below 2 cannot produce a toggling output; they run as 2.
  function automatic ratio_t clamp_ratio(input ratio_t r);
    return (r < ratio_t'(2)) ? ratio_t'(2) : r;
  endfunction

  // Output level for the counter value the channel is about to hold.
  // Square: high for ceil(R/2) cycles, then low. Tick: high only at count 0.
  function automatic logic out_for(input logic   tick_mode,
                                   input ratio_t cnt_next,
                                   input ratio_t ratio);
    ratio_t r_eff;
    ratio_t high_len;
    r_eff    = clamp_ratio(ratio);
    high_len = r_eff - (r_eff >> 1);
    return tick_mode ? (cnt_next == '0) : (cnt_next < high_len);
  endfunction

  // Per-channel state. ratio holds the value as captured; the clamp is
  // applied wherever it is used.
  ratio_t            ratio_q    [NUM_CH];
  ratio_t            ratio_d    [NUM_CH];
  ratio_t            pend_val_q [NUM_CH];
  ratio_t            pend_val_d [NUM_CH];
  ratio_t            cnt_q      [NUM_CH];
  ratio_t            cnt_d      [NUM_CH];
  logic [NUM_CH-1:0] running_q, running_d;
  logic [NUM_CH-1:0] out_q,     out_d;
  logic [NUM_CH-1:0] pend_q,    pend_d;

  // Decoded per-channel conditions.
  ratio_t            new_ratio  [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] restart;

  // Period-boundary and restart detection for each channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      new_ratio[i] = bus.div_ratio[i*DIV_W +: DIV_W];
      wrap[i]      = (cnt_q[i] == clamp_ratio(ratio_q[i]) - ratio_t'(1));
      // Sync, stop and start all put the channel at count 0 with any staged
      // ratio applied; only the enable decides whether it then runs.
      restart[i]   = bus.sync | ~bus.enable[i] | ~running_q[i];
    end
  end

  // Next-state logic for every channel.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path can leave it unassigned, which would infer a latch.
    ratio_d    = ratio_q;
    pend_val_d = pend_val_q;
    cnt_d      = cnt_q;
    running_d  = running_q;
    out_d      = out_q;
    pend_d     = pend_q;

    for (int i = 0; i < NUM_CH; i++) begin
      if (restart[i]) begin
        // A ratio presented now wins over one staged earlier.
        if (bus.load) begin
          ratio_d[i]    = new_ratio[i];
          pend_val_d[i] = new_ratio[i];
        end else if (pend_q[i]) begin
          ratio_d[i]    = pend_val_q[i];
        end
        pend_d[i]    = 1'b0;
        running_d[i] = bus.enable[i];
        cnt_d[i]     = '0;
        out_d[i]     = bus.enable[i];
      end else if (wrap[i]) begin
        // Period boundary: the staged ratio takes over for the period that
        // starts on this edge. A load on this same edge is staged for the
        // following boundary.
        if (pend_q[i]) begin
          ratio_d[i] = pend_val_q[i];
        end
        if (bus.load) begin
          pend_val_d[i] = new_ratio[i];
        end
        pend_d[i] = bus.load;
        cnt_d[i]  = '0;
        out_d[i]  = out_for(bus.mode[i], '0, ratio_d[i]);
      end else begin
        if (bus.load) begin
          pend_val_d[i] = new_ratio[i];
          pend_d[i]     = 1'b1;
        end
        cnt_d[i] = cnt_q[i] + ratio_t'(1);
        out_d[i] = out_for(bus.mode[i], cnt_q[i] + ratio_t'(1), ratio_q[i]);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the per-channel arrays are control state, not storage, so every
      // entry is reset explicitly to its defined value.
      for (int i = 0; i < NUM_CH; i++) begin
        ratio_q[i]    <= DEFAULT_DIV[i*DIV_W +: DIV_W];
        pend_val_q[i] <= DEFAULT_DIV[i*DIV_W +: DIV_W];
        cnt_q[i]      <= '0;
      end
      running_q <= '0;
      out_q     <= '0;
      pend_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      ratio_q    <= ratio_d;
      pend_val_q <= pend_val_d;
      cnt_q      <= cnt_d;
      running_q  <= running_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.clk_out = out_q;
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a period-position
// reference model, plus directed waveform-shape checks.
module tb_clock_divider_bank;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 24;
  localparam logic [NUM_CH*DIV_W-1:0] DEF = {24'd2941176, 24'd5882, 24'd2500};

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clock_divider_bank_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clock_divider_bank #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: position inside the current period and the ratio that
  // governs it; a staged ratio takes over when a period is complete.
  int unsigned       m_ratio [NUM_CH];
  int unsigned       m_stage [NUM_CH];
  int unsigned       m_pos   [NUM_CH];
  logic [NUM_CH-1:0] m_run, m_pend, m_out;

  logic [NUM_CH-1:0] hist[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned eff(input int unsigned r);
    return (r < 2) ? 2 : r;
  endfunction

  task automatic model_edge();
    int unsigned dr;
    int unsigned len;
    for (int i = 0; i < NUM_CH; i++) begin
      dr = bus.div_ratio[i*DIV_W +: DIV_W];
      if (!reset) begin
        m_ratio[i] = DEF[i*DIV_W +: DIV_W];
        m_stage[i] = DEF[i*DIV_W +: DIV_W];
        m_pos[i]   = 0;
        m_run[i]   = 1'b0;
        m_pend[i]  = 1'b0;
        m_out[i]   = 1'b0;
      end else if (bus.sync || !bus.enable[i] || !m_run[i]) begin
        if (bus.load) begin
          m_ratio[i] = dr;
          m_stage[i] = dr;
        end else if (m_pend[i]) begin
          m_ratio[i] = m_stage[i];
        end
        m_pend[i] = 1'b0;
        m_run[i]  = bus.enable[i];
        m_pos[i]  = 0;
        m_out[i]  = bus.enable[i];
      end else begin
        m_pos[i] = m_pos[i] + 1;
        if (m_pos[i] == eff(m_ratio[i])) begin
          m_pos[i] = 0;
          if (m_pend[i]) m_ratio[i] = m_stage[i];
          m_pend[i] = 1'b0;
        end
        if (bus.load) begin
          m_stage[i] = dr;
          m_pend[i]  = 1'b1;
        end
        len      = eff(m_ratio[i]);
        m_out[i] = bus.mode[i] ? (m_pos[i] == 0) : (m_pos[i] < (len + 1) / 2);
      end
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      hist.push_back(bus.clk_out);
      check("clk_out", bus.clk_out, m_out);
      check("pending", bus.pending, m_pend);
    end
  endtask

  function automatic int count_high(input int ch, input int from, input int len);
    int s = 0;
    for (int k = from; k < from + len; k++) s += int'(hist[k][ch]);
    return s;
  endfunction

  function automatic logic [15:0] pattern(input int ch, input int from, input int len);
    logic [15:0] v = '0;
    for (int k = 0; k < len; k++) v = {v[14:0], hist[from+k][ch]};
    return v;
  endfunction

  task automatic set_ratios(input int unsigned r0, input int unsigned r1, input int unsigned r2);
    bus.div_ratio = {DIV_W'(r2), DIV_W'(r1), DIV_W'(r0)};
  endtask

  initial begin
    reset = 1'b0;
    bus.enable = '0; bus.mode = '0; bus.load = 1'b0; bus.sync = 1'b0;
    bus.div_ratio = DEF;

    // 1: reset state, then ch0 at its default ratio 2500.
    step(3);
    check("rst_clk_out", bus.clk_out, 0);
    check("rst_pending", bus.pending, 0);
    reset = 1'b1;
    bus.enable = 3'b001;
    hist.delete();
    step(5000);
    check("t1_first_high", count_high(0, 0, 1250), 1250);
    check("t1_first_low",  count_high(0, 1250, 1250), 0);
    check("t1_period2",    hist[2500][0], 1);

    // 2: ch1 ratio 5 loaded while idle; square 3/2, then tick 1/4.
    bus.enable = 3'b000;
    set_ratios(2500, 5, 2941176);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    bus.enable = 3'b010;
    hist.delete();
    step(20);
    check("t2_square", pattern(1, 0, 10), 16'b1110011100);
    bus.mode = 3'b010;
    hist.delete();
    step(10);
    check("t2_tick", pattern(1, 0, 10), 16'b1000010000);

    // 3: ch0 at 2500, load 1000 at cnt 700; pending until the wrap.
    bus.mode = 3'b000;
    bus.enable = 3'b001;
    step(701);
    set_ratios(1000, 5, 2941176);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("t3_pend_set", bus.pending[0], 1);
    step(1798);
    check("t3_pend_hold", bus.pending[0], 1);
    check("t3_tail_low", bus.clk_out[0], 0);
    hist.delete();
    step(2001);
    check("t3_pend_drop", bus.pending[0], 0);
    check("t3_new_high", count_high(0, 0, 1000), 500);
    check("t3_new_period", pattern(0, 999, 2), 16'b01);
    check("t3_third_period", hist[2000][0], 1);

    // 4: ch0 R=10 and ch1 R=7 out of phase, then sync (tick mode).
    bus.enable = 3'b000;
    set_ratios(10, 7, 2941176);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    bus.mode = 3'b011;
    bus.enable = 3'b001;
    step(3);
    bus.enable = 3'b011;
    step(5);
    bus.sync = 1'b1;
    hist.delete();
    step(1);
    bus.sync = 1'b0;
    check("t4_sync_out", bus.clk_out[1:0], 2'b11);
    step(70);
    begin
      int both = 0;
      for (int k = 1; k <= 70; k++) both += int'(hist[k][1:0] == 2'b11);
      check("t4_realign_count", both, 1);
    end
    check("t4_realign_70", hist[70][1:0], 2'b11);

    // 5: ratios 0 and 1 run as 2.
    bus.enable = 3'b000;
    set_ratios(0, 1, 2941176);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    bus.mode = 3'b010;
    bus.enable = 3'b011;
    hist.delete();
    step(8);
    check("t5_square_r0", pattern(0, 0, 8), 16'b10101010);
    check("t5_tick_r1",   pattern(1, 0, 8), 16'b10101010);

    // 6: reset mid-period with a staged ratio.
    bus.enable = 3'b000;
    bus.mode = 3'b000;
    set_ratios(10, 1, 2941176);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    bus.enable = 3'b001;
    step(3);
    set_ratios(20, 1, 2941176);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("t6_pend_before_rst", bus.pending[0], 1);
    step(2);
    reset = 1'b0;
    step(1);
    check("t6_rst_out", bus.clk_out, 0);
    check("t6_rst_pend", bus.pending, 0);
    reset = 1'b1;
    hist.delete();
    step(1300);
    check("t6_default_high", count_high(0, 0, 1300), 1250);

    // 6b: load coinciding with a wrap is applied one period later.
    bus.enable = 3'b000;
    set_ratios(10, 1, 2941176);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    bus.enable = 3'b001;
    step(10);
    set_ratios(4, 1, 2941176);
    bus.load = 1'b1;
    hist.delete();
    step(1);
    bus.load = 1'b0;
    check("t6_wrap_load_pend", bus.pending[0], 1);
    step(9);
    check("t6_wrap_pend_hold", bus.pending[0], 1);
    step(8);
    check("t6_old_period", count_high(0, 0, 10), 5);
    check("t6_new_periods", pattern(0, 10, 8), 16'b11001100);
    check("t6_pend_applied", bus.pending[0], 0);

    // Randomized traffic against the model.
    bus.enable = 3'b011;
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(499) != 0);
      bus.load = ($urandom_range(15) == 0);
      bus.sync = ($urandom_range(59) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(39) == 0) bus.enable[i] = ~bus.enable[i];
        if ($urandom_range(29) == 0) bus.mode[i]   = ~bus.mode[i];
        bus.div_ratio[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(14));
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
